// File: rtl/regwrite_arbiter.sv
// Shares the regfile write port between writeback and a 1-entry MDU
// holding buffer; an ageing counter forces the buffered result through.
//
// Ports:
//   clk, reset (async, active-high)
//   pipe_valid/pipe_dst/pipe_data : writeback register write
//   pipe_stall                    : writeback must hold this cycle
//   mdu_valid/mdu_dst/mdu_data    : MDU result, accepted when mdu_ready
//   wvalid/wa/wd                  : regfile write port
//   pending/pending_dst           : buffer occupancy for decode hazards
module regwrite_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_valid,
  input  logic [ADDR_W-1:0] pipe_dst,
  input  logic [DATA_W-1:0] pipe_data,
  output logic              pipe_stall,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [ADDR_W-1:0] mdu_dst,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              wvalid,
  output logic [ADDR_W-1:0] wa,
  output logic [DATA_W-1:0] wd,
  output logic              pending,
  output logic [ADDR_W-1:0] pending_dst
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] buf_dst;
  logic [DATA_W-1:0] buf_data;
  logic [CW-1:0]     wait_cnt;

  logic buf_valid;
  logic aged;
  logic clash;
  logic buf_gnt;
  logic pipe_gnt;

  assign buf_valid = (state == HELD);
  assign aged      = (wait_cnt == CW'(MAX_WAIT));
  assign clash     = (pipe_dst == buf_dst);

  // Same-dst collision drains the older buffered write first.
  assign buf_gnt  = buf_valid &&
                    (!pipe_valid || aged || clash);
  assign pipe_gnt = !buf_gnt && pipe_valid;

  assign mdu_ready   = !buf_valid;
  assign pending     = buf_valid;
  assign pending_dst = buf_valid ? buf_dst : '0;
  assign pipe_stall  = pipe_valid && buf_gnt;

  // Writes to x0 are consumed but never enabled.
  always_comb begin
    wvalid = 1'b0;
    wa     = '0;
    wd     = '0;
    unique case (1'b1)
      buf_gnt: begin
        wvalid = (buf_dst != '0);
        wa     = buf_dst;
        wd     = buf_data;
      end
      pipe_gnt: begin
        wvalid = (pipe_dst != '0);
        wa     = pipe_dst;
        wd     = pipe_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      buf_dst  <= '0;
      buf_data <= '0;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (mdu_valid) begin
            state    <= HELD;
            buf_dst  <= mdu_dst;
            buf_data <= mdu_data;
            wait_cnt <= '0;
          end
        end
        HELD: begin
          if (buf_gnt) begin
            state    <= EMPTY;
            wait_cnt <= '0;
          end else if (!aged) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
